// File: rtl/counter_3_2_7_3.sv
// rtl/counter_3_2_7_3.sv - 3:2 and 7:3 bit-count compressors with registered copies

module fa_3_2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

module counter_3_2_7_3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in3,
    output logic [1:0] out3,
    output logic [1:0] out3_q,
    input  logic [6:0] in7,
    output logic [2:0] out7,
    output logic [2:0] out7_q
);

    logic s1, c1, s2, c2, c3;

    fa_3_2 u_fa_3 (
        .a     (in3[0]),
        .b     (in3[1]),
        .c     (in3[2]),
        .sum   (out3[0]),
        .carry (out3[1])
    );

    // 7:3 tree: two leaf cells, one cell merging the weight-1 sums with in7[6],
    // and one cell summing the three weight-2 carries.
    fa_3_2 u_fa_7_1 (
        .a     (in7[0]),
        .b     (in7[1]),
        .c     (in7[2]),
        .sum   (s1),
        .carry (c1)
    );

    fa_3_2 u_fa_7_2 (
        .a     (in7[3]),
        .b     (in7[4]),
        .c     (in7[5]),
        .sum   (s2),
        .carry (c2)
    );

    fa_3_2 u_fa_7_3 (
        .a     (s1),
        .b     (s2),
        .c     (in7[6]),
        .sum   (out7[0]),
        .carry (c3)
    );

    fa_3_2 u_fa_7_4 (
        .a     (c1),
        .b     (c2),
        .c     (c3),
        .sum   (out7[1]),
        .carry (out7[2])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out3_q <= 2'b00;
            out7_q <= 3'b000;
        end else begin
            out3_q <= out3;
            out7_q <= out7;
        end
    end

endmodule

// File: tb/tb_counter_3_2_7_3.sv
// tb/tb_counter_3_2_7_3.sv - randomized self-checking bench for counter_3_2_7_3

module tb_counter_3_2_7_3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in3;
    logic [1:0] out3;
    logic [1:0] out3_q;
    logic [6:0] in7;
    logic [2:0] out7;
    logic [2:0] out7_q;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] a3;
    logic [6:0] a7;
    logic [6:0] last_in7;

    counter_3_2_7_3 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in3    (in3),
        .out3   (out3),
        .out3_q (out3_q),
        .in7    (in7),
        .out7   (out7),
        .out7_q (out7_q)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: count of set bits, computed bit by bit.
    function automatic logic [31:0] ones(input logic [31:0] v);
        logic [31:0] n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = n + 1;
        end
        return n;
    endfunction

    initial begin
        rst_n = 1'b0;
        in3   = 3'b000;
        in7   = 7'b0000000;
        #2;
        check_val("rst_out3_q", 32'(out3_q), 0);
        check_val("rst_out7_q", 32'(out7_q), 0);
        check_val("rst_out3", 32'(out3), 0);
        check_val("rst_out7", 32'(out7), 0);

        // Combinational outputs stay live while the registers are held in reset.
        a3 = 3'($urandom);
        a7 = 7'($urandom);
        in3 = a3;
        in7 = a7;
        #1;
        check_val("rst_comb_out3", 32'(out3), ones(32'(a3)));
        check_val("rst_comb_out7", 32'(out7), ones(32'(a7)));
        @(posedge clk);
        #1;
        check_val("rst_hold_out3_q", 32'(out3_q), 0);
        check_val("rst_hold_out7_q", 32'(out7_q), 0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            a3  = 3'(i);
            a7  = 7'($urandom);
            in3 = a3;
            in7 = a7;
            #1;
            check_val("exh_out3", 32'(out3), ones(32'(a3)));
            check_val("exh3_out7", 32'(out7), ones(32'(a7)));
        end

        for (int i = 0; i < 128; i++) begin
            a7  = 7'(i);
            a3  = 3'($urandom);
            in7 = a7;
            in3 = a3;
            #1;
            check_val("exh_out7", 32'(out7), ones(32'(a7)));
            check_val("exh7_out3", 32'(out3), ones(32'(a3)));
        end

        in7 = 7'b1010101;
        #1;
        check_val("out7_1010101", 32'(out7), 4);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a3  = 3'($urandom);
            a7  = 7'($urandom);
            in3 = a3;
            in7 = a7;
            #1;
            check_val("rnd_out3", 32'(out3), ones(32'(a3)));
            check_val("rnd_out7", 32'(out7), ones(32'(a7)));
            @(posedge clk);
            #1;
            check_val("rnd_out3_q", 32'(out3_q), ones(32'(a3)));
            check_val("rnd_out7_q", 32'(out7_q), ones(32'(a7)));
        end
        last_in7 = a7;

        // One-cycle latency: comb sees the new value before the edge, the register after.
        @(negedge clk);
        in7 = 7'b0111111;
        #1;
        check_val("lat_out7_pre", 32'(out7), 6);
        check_val("lat_out7_q_pre", 32'(out7_q), ones(32'(last_in7)));
        @(posedge clk);
        #1;
        check_val("lat_out7_q_post", 32'(out7_q), 6);

        @(negedge clk);
        in7 = 7'b1111111;
        in3 = 3'b111;
        @(posedge clk);
        #1;
        check_val("full_out7_q", 32'(out7_q), 7);
        check_val("full_out3_q", 32'(out3_q), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_out7_q", 32'(out7_q), 0);
        check_val("async_out3_q", 32'(out3_q), 0);
        @(posedge clk);
        #1;
        check_val("async_hold_out7_q", 32'(out7_q), 0);
        check_val("async_hold_out3_q", 32'(out3_q), 0);

        @(negedge clk);
        in3 = 3'b101;
        #1;
        rst_n = 1'b1;
        #1;
        check_val("rel_out3_q_pre", 32'(out3_q), 0);
        check_val("rel_out3", 32'(out3), 2);
        @(posedge clk);
        #1;
        check_val("rel_out3_q_post", 32'(out3_q), 2);
        check_val("rel_out7_q_post", 32'(out7_q), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
